multdiv_ctrl: RTL and testbench
===============================

# multdiv_ctrl

Sequencing controller between the execute stage and the multicycle `multdiv` unit. It accepts a MULT or DIV request from the execute stage and holds the operands stable for the whole operation. It issues the single-cycle start pulse, stalls the pipeline until `data_resultRDY`, then presents one writeback beat. On an exception, a watchdog timeout or a pipeline flush, the writeback is redirected to `$rstatus` or suppressed.

## Interface

Parameters:
- `MAX_CYCLES`, 40: number of WAIT cycles before a forced timeout.
- `MULT_EXC_CODE`, 32'd4: `$rstatus` value written on a mult exception.
- `DIV_EXC_CODE`, 32'd5: `$rstatus` value written on a div exception.
- `TIMEOUT_CODE`, 32'd6: `$rstatus` value written on a timeout.
- `RSTATUS_REG`, 5'd30: register index of `$rstatus`.

Ports:
- `clock` in 1: single clock, all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start_mult` in 1: execute stage holds a MULT.
- `start_div` in 1: execute stage holds a DIV.
- `flush` in 1: squash any in-flight operation.
- `opA` in 32: operand A from execute.
- `opB` in 32: operand B from execute.
- `rd` in 5: destination register.
- `md_operandA` out 32: latched operand A to `multdiv`.
- `md_operandB` out 32: latched operand B to `multdiv`.
- `md_ctrl_MULT` out 1: start pulse for a mult.
- `md_ctrl_DIV` out 1: start pulse for a div.
- `md_result` in 32: result from `multdiv`.
- `md_exception` in 1: exception flag from `multdiv`.
- `md_resultRDY` in 1: result-ready flag from `multdiv`.
- `stall` out 1: freeze fetch, decode and execute.
- `busy` out 1: FSM is not IDLE.
- `wb_valid` out 1: writeback beat is valid.
- `wb_rd` out 5: writeback register index.
- `wb_data` out 32: writeback data.
- `wb_exception` out 1: writeback is an `$rstatus` write.

## Operation

- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - On `start_mult|start_div` with `!flush`, latch `opA`, `opB`, `rd` and `op_is_mult`, then go to ISSUE.
  - If both starts are high, MULT wins.
- **ISSUE**
  - Assert exactly one of `md_ctrl_MULT`/`md_ctrl_DIV` for this single cycle.
  - Clear the watchdog counter and go to WAIT.
  - `md_resultRDY` is ignored in this cycle, because a stale RDY from a prior operation may still be high.
- **WAIT**
  - The counter increments each cycle.
  - On `md_resultRDY`, capture the result, then go to DONE:
    - normal: `wb_data=md_result`, `wb_rd`=latched rd, `wb_exception=0`;
    - if `md_exception`: `wb_rd=RSTATUS_REG`, `wb_data` = MULT_EXC_CODE or DIV_EXC_CODE per latched op, `wb_exception=1`.
  - If the counter reaches MAX_CYCLES without RDY, capture a timeout: `wb_rd=RSTATUS_REG`, `wb_data=TIMEOUT_CODE`, `wb_exception=1`, then go to DONE.
- **DONE**
  - `wb_valid=1` for one cycle, then go to IDLE.
  - Start inputs are ignored in DONE; the same instruction is still in execute while it advances.
- **Operand latch:** `md_operandA/B` drive the latched values from ISSUE until the next accept. `multdiv` requires stable operands throughout.
- **`stall`** (combinational):
  - high in IDLE when a start is asserted and `!flush`;
  - high in ISSUE and WAIT;
  - low in DONE and otherwise.
- **`busy`** = state != IDLE.
- **`flush`**
  - In ISSUE or WAIT: go to IDLE next cycle with no writeback and no pulse on the following edge.
  - In DONE: `wb_valid` is suppressed in that cycle.
  - The in-flight `multdiv` result is discarded; the next start pulse resets `multdiv`.
- **Reset**
  - Effect: state=IDLE, all outputs 0, latches and counter 0.
  - Priority: reset overrides flush and start.
  - Mid-operation: returns to IDLE, no writeback.

## Timing

- Cycle 0: start seen in IDLE; `stall=1`.
- Cycle 1: ISSUE, start pulse high.
- Cycles 2..: WAIT.
- RDY sampled in WAIT at cycle k puts DONE at k+1: `wb_valid=1`, `stall=0`.
- Total stall = k+1 cycles. Back-to-back ops have one IDLE cycle between DONE and the next accept.
- Watchdog: WAIT lasts at most MAX_CYCLES cycles; the timeout DONE comes at cycle MAX_CYCLES+2 after accept.
- Registered outputs: `wb_*`, `md_ctrl_*`, `md_operand*`. Combinational outputs: `stall`, `busy`.

## Test plan

- **Reset values:** assert reset for 2 cycles -> all outputs 0, `busy=0`.
- **Basic mult:** `start_mult`, opA=6, opB=7, rd=5; model RDY at cycle 18 -> single-cycle `md_ctrl_MULT` at cycle 1; DONE at 19 with `wb_valid=1`, wb_rd=5, wb_data=42; `stall` high cycles 0–18.
- **Signed div:** `start_div`, opA=-20, opB=3, rd=7 -> wb_data=0xFFFFFFFA (-6), `wb_exception=0`.
- **Exceptions:** divide by zero -> wb_rd=30, wb_data=5, `wb_exception=1`. Mult 0x40000000×4 overflow -> wb_rd=30, wb_data=4.
- **Stale RDY / timeout:** hold `md_resultRDY=1` during ISSUE -> not accepted. Hold RDY low -> DONE at cycle 42 with wb_data=6.
- **Flush / reset mid-op:** `flush` at WAIT cycle 5 -> IDLE next cycle, no `wb_valid`, `stall` drops. Repeat with reset -> same. A following mult 3×3 completes with wb_data=9.

Source files
------------

// File: rtl/multdiv_ctrl_if.sv
// Execute-stage / multdiv / writeback signal bundle for multdiv_ctrl.
// The slave modport is the controller's view; master is the surrounding
// pipeline plus the multdiv unit.
interface multdiv_ctrl_if;
  logic        start_mult;
  logic        start_div;
  logic        flush;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [4:0]  rd;
  logic [31:0] md_operandA;
  logic [31:0] md_operandB;
  logic        md_ctrl_MULT;
  logic        md_ctrl_DIV;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_resultRDY;
  logic        stall;
  logic        busy;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_exception;

  modport slave (
    input  start_mult, start_div, flush, opA, opB, rd,
    input  md_result, md_exception, md_resultRDY,
    output md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
    output stall, busy, wb_valid, wb_rd, wb_data, wb_exception
  );

  modport master (
    output start_mult, start_div, flush, opA, opB, rd,
    output md_result, md_exception, md_resultRDY,
    input  md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
    input  stall, busy, wb_valid, wb_rd, wb_data, wb_exception
  );
endinterface

// File: rtl/multdiv_ctrl.sv
// Sequencer between the execute stage and the multicycle multdiv unit.
// Latches operands on accept, fires a one-cycle start pulse, stalls the
// pipeline until the result is ready (or the watchdog fires) and emits a
// single writeback beat, redirected to $rstatus on exception/timeout.
//
//   state | meaning
//   IDLE  | waiting for a MULT/DIV from execute
//   ISSUE | start pulse to multdiv, watchdog cleared
//   WAIT  | counting cycles until md_resultRDY or timeout
//   DONE  | writeback beat presented for one cycle
module multdiv_ctrl #(
  parameter int          MAX_CYCLES    = 40,
  parameter logic [31:0] MULT_EXC_CODE = 32'd4,
  parameter logic [31:0] DIV_EXC_CODE  = 32'd5,
  parameter logic [31:0] TIMEOUT_CODE  = 32'd6,
  parameter logic [4:0]  RSTATUS_REG   = 5'd30
) (
  input  logic           clock,
  input  logic           reset,
  multdiv_ctrl_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int CW = $clog2(MAX_CYCLES + 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   opa_q, opa_d;
  logic [31:0]   opb_q, opb_d;
  logic [4:0]    rd_q, rd_d;
  logic          is_mult_q, is_mult_d;
  logic          pulse_mult_q, pulse_mult_d;
  logic          pulse_div_q, pulse_div_d;
  logic          wb_valid_q, wb_valid_d;
  logic [4:0]    wb_rd_q, wb_rd_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic          wb_exc_q, wb_exc_d;
  logic          accept;

  assign accept = (bus.start_mult | bus.start_div) & ~bus.flush;

  // Next-state and capture logic for the sequencing FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    rd_d         = rd_q;
    is_mult_d    = is_mult_q;
    pulse_mult_d = 1'b0;
    pulse_div_d  = 1'b0;
    wb_valid_d   = 1'b0;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    wb_exc_d     = wb_exc_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          opa_d        = bus.opA;
          opb_d        = bus.opB;
          rd_d         = bus.rd;
          is_mult_d    = bus.start_mult;
          pulse_mult_d = bus.start_mult;
          pulse_div_d  = ~bus.start_mult;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // RDY is deliberately not looked at here: it may be stale.
        cnt_d   = '0;
        state_d = bus.flush ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (bus.flush) begin
          state_d = S_IDLE;
        end else if (bus.md_resultRDY) begin
          state_d    = S_DONE;
          wb_valid_d = 1'b1;
          if (bus.md_exception) begin
            wb_rd_d   = RSTATUS_REG;
            wb_data_d = is_mult_q ? MULT_EXC_CODE : DIV_EXC_CODE;
            wb_exc_d  = 1'b1;
          end else begin
            wb_rd_d   = rd_q;
            wb_data_d = bus.md_result;
            wb_exc_d  = 1'b0;
          end
        end else if (cnt_d == CW'(MAX_CYCLES)) begin
          state_d    = S_DONE;
          wb_valid_d = 1'b1;
          wb_rd_d    = RSTATUS_REG;
          wb_data_d  = TIMEOUT_CODE;
          wb_exc_d   = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, latches and registered outputs; reset takes priority over all.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      rd_q         <= '0;
      is_mult_q    <= 1'b0;
      pulse_mult_q <= 1'b0;
      pulse_div_q  <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      wb_exc_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      rd_q         <= rd_d;
      is_mult_q    <= is_mult_d;
      pulse_mult_q <= pulse_mult_d;
      pulse_div_q  <= pulse_div_d;
      wb_valid_q   <= wb_valid_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      wb_exc_q     <= wb_exc_d;
    end
  end

  // A flush arriving in DONE must kill the beat in that same cycle, hence
  // the gate on the otherwise registered valid.
  assign bus.wb_valid     = wb_valid_q & ~bus.flush;
  assign bus.wb_rd        = wb_rd_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.wb_exception = wb_exc_q;
  assign bus.md_operandA  = opa_q;
  assign bus.md_operandB  = opb_q;
  assign bus.md_ctrl_MULT = pulse_mult_q;
  assign bus.md_ctrl_DIV  = pulse_div_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.stall        = ((state_q == S_IDLE) & accept) |
                            (state_q == S_ISSUE) | (state_q == S_WAIT);

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Bench for multdiv_ctrl: a behavioural multdiv stand-in, a driver issuing
// directed and random operations, and a scoreboard monitor on the
// writeback port.
module tb_multdiv_ctrl;
  localparam int MAXC = 40;
  localparam longint IMAX = 64'sh0000_0000_7FFF_FFFF;
  localparam longint IMIN = -64'sh0000_0000_8000_0000;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exc;
    int          cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   md_lat = 0;
  exp_t sbq[$];
  exp_t mx;

  multdiv_ctrl_if bus();

  multdiv_ctrl #(
    .MAX_CYCLES(MAXC), .MULT_EXC_CODE(32'd4), .DIV_EXC_CODE(32'd5),
    .TIMEOUT_CODE(32'd6), .RSTATUS_REG(5'd30)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Arithmetic the multdiv unit is expected to perform, with its exception rules.
  function automatic void ref_op(input bit m, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] res, output bit exc);
    longint p;
    res = '0;
    exc = 1'b0;
    if (m) begin
      p   = longint'($signed(a)) * longint'($signed(b));
      res = p[31:0];
      exc = (p > IMAX) || (p < IMIN);
    end else if (b == 32'd0) begin
      exc = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      exc = 1'b1;
    end else begin
      p   = longint'($signed(a)) / longint'($signed(b));
      res = p[31:0];
    end
  endfunction

  // multdiv stand-in: sees the start pulse, drops RDY one cycle later, then
  // raises RDY md_lat cycles after that (never if md_lat is 0) and holds it.
  initial begin
    int  remaining;
    bit  seen, seen_mult, cur_mult, e;
    logic [31:0] r;
    remaining = 0; seen = 0; seen_mult = 0; cur_mult = 0;
    bus.md_resultRDY = 1'b0;
    bus.md_exception = 1'b0;
    bus.md_result    = '0;
    forever begin
      @(negedge clock);
      if (seen) begin
        seen = 0;
        bus.md_resultRDY = 1'b0;
        bus.md_exception = 1'b0;
        remaining = md_lat;
        cur_mult = seen_mult;
      end else if (remaining > 0) begin
        remaining--;
        if (remaining == 0) begin
          ref_op(cur_mult, bus.md_operandA, bus.md_operandB, r, e);
          bus.md_result    = e ? 32'hDEAD_BEEF : r;
          bus.md_exception = e;
          bus.md_resultRDY = 1'b1;
        end
      end
      if (bus.md_ctrl_MULT | bus.md_ctrl_DIV) begin
        seen = 1;
        seen_mult = bus.md_ctrl_MULT;
      end
    end
  end

  // Scoreboard monitor on the writeback port.
  always @(negedge clock) begin
    #2;
    if (bus.wb_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got wb_valid=1 rd=%0d data=0x%08h, required no writeback (cycle %0d)",
                 bus.wb_rd, bus.wb_data, cyc);
      end else begin
        mx = sbq.pop_front();
        chk("wb_cycle", cyc, mx.cyc);
        chk("wb_rd", 32'(bus.wb_rd), 32'(mx.rd));
        chk("wb_data", bus.wb_data, mx.data);
        chk("wb_exception", 32'(bus.wb_exception), 32'(mx.exc));
      end
    end else if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
      mx = sbq.pop_front();
      checks++;
      errors++;
      $display("FAIL wb_missing: got no writeback, required one at cycle %0d (now %0d)", mx.cyc, cyc);
    end
  end

  // Issue one operation from a negedge with the controller idle. kill>0
  // aborts at that cycle after accept (flush, or reset if kill_rst);
  // flush_done flushes during the DONE cycle.
  task automatic run_op(input bit m, input bit both, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r, input int lat, input int kill, input bit kill_rst,
                        input bit flush_done);
    int c0, dn;
    bit em, e;
    logic [31:0] res;
    exp_t x;
    em = m | both;
    dn = (lat > 0) ? lat + 3 : MAXC + 2;
    md_lat = lat;
    bus.start_mult = m | both;
    bus.start_div  = ~m | both;
    bus.opA = a;
    bus.opB = b;
    bus.rd  = r;
    c0 = cyc;
    if (kill == 0 && !flush_done) begin
      if (lat == 0) begin
        x.rd = 5'd30; x.data = 32'd6; x.exc = 1'b1;
      end else begin
        ref_op(em, a, b, res, e);
        if (e) begin
          x.rd = 5'd30; x.data = em ? 32'd4 : 32'd5; x.exc = 1'b1;
        end else begin
          x.rd = r; x.data = res; x.exc = 1'b0;
        end
      end
      x.cyc = c0 + dn;
      sbq.push_back(x);
    end
    #1 chk("stall_accept", 32'(bus.stall), 32'd1);
    for (int n = 1; n <= dn; n++) begin
      @(negedge clock);
      if (n == 1) begin
        chk("pulse_mult", 32'(bus.md_ctrl_MULT), 32'(em));
        chk("pulse_div", 32'(bus.md_ctrl_DIV), 32'(!em));
        bus.opA = $urandom;
        bus.opB = $urandom;
        bus.rd  = 5'($urandom);
      end
      if (n == 2) begin
        chk("pulse_single", 32'({bus.md_ctrl_MULT, bus.md_ctrl_DIV}), 32'd0);
        chk("operandA_held", bus.md_operandA, a);
        chk("operandB_held", bus.md_operandB, b);
      end
      if (n < dn) chk("stall_busy", 32'({bus.stall, bus.busy}), 32'd3);
      if (n == kill) begin
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
        if (kill_rst) reset = 1'b1; else bus.flush = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        bus.flush = 1'b0;
        #1 chk("abort_idle", 32'({bus.busy, bus.stall, bus.wb_valid}), 32'd0);
        return;
      end
      if (n == dn) begin
        chk("stall_done", 32'(bus.stall), 32'd0);
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
        if (flush_done) bus.flush = 1'b1;
        @(negedge clock);
        bus.flush = 1'b0;
        #1 chk("idle_after_done", 32'(bus.busy), 32'd0);
        return;
      end
    end
  endtask

  initial begin
    logic [31:0] a, b;
    int lat, dn, k, sel;
    bit m, both, kr, fd;
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    bus.flush      = 1'b0;
    bus.opA = '0;
    bus.opB = '0;
    bus.rd  = '0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_operandA", bus.md_operandA, 32'd0);
    chk("rst_operandB", bus.md_operandB, 32'd0);
    chk("rst_pulses", 32'({bus.md_ctrl_MULT, bus.md_ctrl_DIV}), 32'd0);
    chk("rst_stall_busy", 32'({bus.stall, bus.busy}), 32'd0);
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
    chk("rst_wb_data", bus.wb_data, 32'd0);
    chk("rst_wb_exception", 32'(bus.wb_exception), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    run_op(1, 0, 32'd6, 32'd7, 5'd5, 16, 0, 0, 0);            // 42 at cycle 19
    run_op(0, 0, -32'sd20, 32'd3, 5'd7, 9, 0, 0, 0);          // -6
    run_op(0, 0, 32'd100, 32'd0, 5'd9, 5, 0, 0, 0);           // divide by zero
    run_op(1, 0, 32'h4000_0000, 32'd4, 5'd3, 7, 0, 0, 0);     // mult overflow
    run_op(1, 0, 32'd5, 32'd5, 5'd4, 0, 0, 0, 0);             // timeout at 42
    run_op(0, 0, 32'd77, 32'd7, 5'd11, 39, 0, 0, 0);          // RDY on last WAIT cycle
    run_op(1, 1, 32'd9, 32'd9, 5'd12, 3, 0, 0, 0);            // both starts: mult
    run_op(1, 0, 32'd1, 32'd2, 5'd13, 20, 6, 0, 0);           // flush in WAIT
    run_op(0, 0, 32'd1, 32'd2, 5'd13, 20, 6, 1, 0);           // reset in WAIT
    run_op(1, 0, 32'd3, 32'd3, 5'd14, 4, 0, 0, 0);            // 9
    run_op(1, 0, 32'd2, 32'd2, 5'd15, 4, 0, 0, 1);            // flush in DONE
    run_op(0, 0, 32'd9, 32'd3, 5'd16, 3, 1, 0, 0);            // flush in ISSUE
    run_op(0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 1, 0, 0, 0);

    for (int i = 0; i < 60; i++) begin
      m    = bit'($urandom_range(0, 1));
      both = ($urandom_range(0, 9) == 0);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 50); end
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: ;
      endcase
      lat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 39));
      dn  = (lat > 0) ? lat + 3 : MAXC + 2;
      k = 0; kr = 0; fd = 0;
      sel = $urandom_range(0, 19);
      if (sel < 2) k = $urandom_range(1, dn - 1);
      else if (sel == 2) begin k = $urandom_range(1, dn - 1); kr = 1; end
      else if (sel == 3) fd = 1;
      run_op(m, both, a, b, 5'($urandom), lat, k, kr, fd);
    end

    repeat (3) @(negedge clock);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
